// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: credit-limited fetch issue, in-order response matching
// against the expected PC, and redirect handling that drains stale responses.
module prefetch_queue #(
   parameter int                ADDR_W   = 32,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              FLUSH,
   input  logic [ADDR_W-1:0] NEW_PC,
   input  logic              MEM_WAIT,
   output logic              INST_RDEN,
   output logic [ADDR_W-1:0] INST_RIADDR,
   input  logic              INST_RVALID,
   input  logic [ADDR_W-1:0] INST_ROADDR,
   input  logic [31:0]       INST_RDATA,
   input  logic              OUT_READY,
   output logic              OUT_VALID,
   output logic [ADDR_W-1:0] OUT_PC,
   output logic [31:0]       OUT_DATA,
   output logic              ADDR_ERR
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0]    CREDIT   = (CNT_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(32'd4);
   localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [PTR_W-1:0]  PTR_ZERO = {PTR_W{1'b0}};

   logic [ADDR_W-1:0] fpc_r;
   logic [ADDR_W-1:0] epc_r;
   logic [CNT_W-1:0]  count_r;
   logic [CNT_W-1:0]  outst_r;
   logic [CNT_W-1:0]  drain_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [PTR_W-1:0]  wr_ptr_r;
   logic              addr_err_r;
   logic [ADDR_W-1:0] pc_mem_r   [DEPTH];
   logic [31:0]       data_mem_r [DEPTH];

   logic [CNT_W:0]    inflight_s;
   logic              rden_s;
   logic              req_acc_s;
   logic              rsp_s;
   logic              drop_s;
   logic              match_s;
   logic              mism_s;
   logic              push_s;
   logic              pop_s;
   logic [CNT_W-1:0]  acc_inc_s;
   logic [CNT_W-1:0]  rsp_dec_s;
   logic [CNT_W-1:0]  drop_dec_s;
   logic [CNT_W-1:0]  push_inc_s;
   logic [CNT_W-1:0]  pop_dec_s;

   // Issue credit, response classification and push/pop qualification
   always_comb begin
      inflight_s = {1'b0, count_r} + {1'b0, outst_r};
      rden_s     = RST & ~FLUSH & (inflight_s < CREDIT);
      req_acc_s  = rden_s & ~MEM_WAIT;
      // a response with nothing outstanding is left over from before reset
      rsp_s      = INST_RVALID & (outst_r != CNT_ZERO);
      drop_s     = rsp_s & (drain_r != CNT_ZERO);
      match_s    = rsp_s & ~drop_s & (INST_ROADDR == epc_r);
      mism_s     = rsp_s & ~drop_s & ~match_s & ~FLUSH;
      push_s     = match_s & ~FLUSH;
      pop_s      = (count_r != CNT_ZERO) & OUT_READY & ~MEM_WAIT & ~FLUSH;
      acc_inc_s  = CNT_W'(req_acc_s);
      rsp_dec_s  = CNT_W'(rsp_s);
      drop_dec_s = CNT_W'(drop_s);
      push_inc_s = CNT_W'(push_s);
      pop_dec_s  = CNT_W'(pop_s);
   end

   // Control state: fetch/expect PCs, occupancy, outstanding and drain counters
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         fpc_r      <= RESET_PC;
         epc_r      <= RESET_PC;
         count_r    <= CNT_ZERO;
         outst_r    <= CNT_ZERO;
         drain_r    <= CNT_ZERO;
         rd_ptr_r   <= PTR_ZERO;
         wr_ptr_r   <= PTR_ZERO;
         addr_err_r <= 1'b0;
      end else if (FLUSH) begin
         fpc_r      <= NEW_PC;
         epc_r      <= NEW_PC;
         count_r    <= CNT_ZERO;
         outst_r    <= outst_r - rsp_dec_s;
         drain_r    <= outst_r - rsp_dec_s;
         rd_ptr_r   <= PTR_ZERO;
         wr_ptr_r   <= PTR_ZERO;
         addr_err_r <= 1'b0;
      end else begin
         if (req_acc_s) begin
            fpc_r <= fpc_r + PC_STEP;
         end
         if (push_s) begin
            epc_r <= epc_r + PC_STEP;
         end
         count_r    <= count_r + push_inc_s - pop_dec_s;
         outst_r    <= outst_r + acc_inc_s - rsp_dec_s;
         drain_r    <= drain_r - drop_dec_s;
         rd_ptr_r   <= rd_ptr_r + PTR_W'(pop_s);
         wr_ptr_r   <= wr_ptr_r + PTR_W'(push_s);
         addr_err_r <= mism_s;
      end
   end

   // Entry storage, cleared on reset so the head reads zero while empty
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_r[i]   <= {ADDR_W{1'b0}};
            data_mem_r[i] <= 32'h0;
         end
      end else if (push_s) begin
         pc_mem_r[wr_ptr_r]   <= epc_r;
         data_mem_r[wr_ptr_r] <= INST_RDATA;
      end
   end

   assign INST_RDEN   = rden_s;
   assign INST_RIADDR = fpc_r;
   assign OUT_VALID   = (count_r != CNT_ZERO);
   assign OUT_PC      = pc_mem_r[rd_ptr_r];
   assign OUT_DATA    = data_mem_r[rd_ptr_r];
   assign ADDR_ERR    = addr_err_r;

endmodule

// File: doc/prefetch_queue.md
PREFETCH_QUEUE -- requirements
Module: prefetch_queue

Interface
REQ-001 SHALL take parameter ADDR_W, default 32: width of PC, request and response addresses.
REQ-002 SHALL take parameter DEPTH, default 4: queue entries; power of two, minimum 2.
REQ-003 SHALL take parameter RESET_PC, default 32'h0: first fetch address after reset.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all state on its rising edge.
REQ-005 SHALL have port RST, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port FLUSH, input, 1 bit: redirect request, sampled on the clock edge.
REQ-007 SHALL have port NEW_PC, input, ADDR_W bits: redirect target, valid when FLUSH=1.
REQ-008 SHALL have port MEM_WAIT, input, 1 bit: global memory stall; freezes request acceptance and pop.
REQ-009 SHALL have port INST_RDEN, output, 1 bit: fetch request valid.
REQ-010 SHALL have port INST_RIADDR, output, ADDR_W bits: fetch request address.
REQ-011 SHALL have port INST_RVALID, input, 1 bit: response valid; responses arrive in request order.
REQ-012 SHALL have port INST_ROADDR, input, ADDR_W bits: address echoed with the response.
REQ-013 SHALL have port INST_RDATA, input, 32 bits: instruction word.
REQ-014 SHALL have port OUT_READY, input, 1 bit: consumer accepts the head entry (decode not stalled).
REQ-015 SHALL have port OUT_VALID, output, 1 bit: head entry valid.
REQ-016 SHALL have port OUT_PC, output, ADDR_W bits: head entry PC.
REQ-017 SHALL have port OUT_DATA, output, 32 bits: head entry instruction.
REQ-018 SHALL have port ADDR_ERR, output, 1 bit: one-cycle pulse on a dropped mismatched response.

Function
REQ-019 SHALL keep fpc (next request address), epc (next expected response address), count (0..DEPTH), outst (issued, not yet returned) and drain (stale responses still to discard, drain <= outst).
REQ-020 SHALL drive INST_RDEN=1 iff FLUSH=0 and count+outst < DEPTH, with INST_RIADDR=fpc.
REQ-021 SHALL treat a request as accepted in a cycle with INST_RDEN=1 and MEM_WAIT=0: fpc += 4 (mod 2^ADDR_W) and outst += 1; INST_RIADDR SHALL stay stable until acceptance.
REQ-022 SHALL decrement outst on every cycle with INST_RVALID=1.
REQ-023 SHALL, when INST_RVALID=1 and drain>0, decrement drain and drop the response without pushing it and without raising ADDR_ERR.
REQ-024 SHALL, when INST_RVALID=1, drain=0 and INST_ROADDR=epc, push {epc, INST_RDATA} and advance epc by 4.
REQ-025 SHALL, when INST_RVALID=1, drain=0 and INST_ROADDR!=epc, drop the response, leave epc unchanged and pulse ADDR_ERR for one cycle.
REQ-026 SHALL present the head entry combinationally from storage; OUT_VALID=(count>0).
REQ-027 SHALL pop when OUT_VALID=1, OUT_READY=1 and MEM_WAIT=0.
REQ-028 SHALL allow a push and a pop in the same cycle, count unchanged; by the REQ-020 credit rule a push into a full queue cannot occur.
REQ-029 SHALL, on FLUSH=1: clear the queue (count=0, so OUT_VALID=0 next cycle); set fpc=epc=NEW_PC; issue no request; set drain = outst - INST_RVALID, so that every still-outstanding response is discarded; take no push that cycle.
REQ-030 SHALL treat FLUSH as having priority over a simultaneous pop, push and mismatch; ADDR_ERR SHALL be 0 in a FLUSH cycle.
REQ-031 SHALL use circular read and write pointers of log2(DEPTH) bits that wrap modulo DEPTH.
REQ-032 SHALL give a minimum latency of 1 cycle from a response cycle to OUT_VALID=1.

Reset
REQ-033 SHALL, while RST=0, asynchronously force: count=outst=drain=0, pointers=0, fpc=epc=RESET_PC, OUT_VALID=0, OUT_PC=0, OUT_DATA=0, ADDR_ERR=0.
REQ-034 SHALL, while RST=0, force INST_RDEN=0; the first request is INST_RDEN=1, INST_RIADDR=RESET_PC in the first cycle after release.
REQ-035 SHALL, on reset asserted mid-operation, discard all in-flight responses without reporting ADDR_ERR.

Verification
REQ-036 SHALL be verified with: reset release, memory latency 1, OUT_READY=1 -> OUT_PC sequence 0x0, 0x4, 0x8 with matching data, and no gaps after fill.
REQ-037 SHALL be verified with: OUT_READY=0, DEPTH=4 -> exactly 4 requests accepted, then INST_RDEN=0 with count=4; one pop -> one new request.
REQ-038 SHALL be verified with: FLUSH with NEW_PC=0x100 while 2 responses are outstanding -> both responses dropped, next OUT_PC=0x100, no ADDR_ERR.
REQ-039 SHALL be verified with: response INST_ROADDR=0x20 while epc=0x1C -> ADDR_ERR pulses, nothing pushed, epc stays 0x1C.
REQ-040 SHALL be verified with: MEM_WAIT=1 for 3 cycles with a pending request and OUT_VALID=1 -> INST_RIADDR held, no pop, state frozen, then resumes.
REQ-041 SHALL be verified with: push and pop in the same cycle at count=DEPTH-1, then a pointer wrap past entry 3 -> count steady and PC order preserved.
